accel_mem_arbiter: RTL and testbench

ACCEL_MEM_ARBITER -- requirements
Module: accel_mem_arbiter

---
 rtl/cfg_types_pkg.sv | 18 +
 rtl/accel_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_accel_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_types_pkg.sv
// Shared type definitions for the accelerator/host RAM arbiter.
// Mode and access-owner encodings are visible to both RTL and testbench.
package cfg_types_pkg;

    typedef enum logic {
        ARB_HOST = 1'b0,
        ARB_ACC  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_ACC  = 2'd2
    } owner_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/accel_mem_arbiter.sv
// Arbitrates RAM port a between the host bus and the accelerator. Grants are combinational.
// The response (rvalid/rdata) is steered one cycle later to the registered owner.
module accel_mem_arbiter
    import cfg_types_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MAX_WAIT       = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        accel_busy,

    input  logic                        host_req,
    input  logic [MEM_ADDR_WIDTH-1:0]   host_addr,
    input  logic                        host_we,
    input  logic [MEM_DATA_WIDTH/8-1:0] host_be,
    input  logic [MEM_DATA_WIDTH-1:0]   host_wdata,
    output logic                        host_gnt,
    output logic                        host_rvalid,
    output logic [MEM_DATA_WIDTH-1:0]   host_rdata,

    input  logic                        acc_req,
    input  logic [MEM_ADDR_WIDTH-1:0]   acc_addr,
    input  logic                        acc_we,
    input  logic [MEM_DATA_WIDTH/8-1:0] acc_be,
    input  logic [MEM_DATA_WIDTH-1:0]   acc_wdata,
    output logic                        acc_gnt,
    output logic                        acc_rvalid,
    output logic [MEM_DATA_WIDTH-1:0]   acc_rdata,

    output logic                        mem_en,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic                        mem_we,
    output logic [MEM_DATA_WIDTH/8-1:0] mem_be,
    output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,

    output arb_state_t                  arb_state,
    output logic [STALL_CNT_W-1:0]      host_stall_cnt
);

    localparam int BE_W   = MEM_DATA_WIDTH / 8;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    arb_state_t             state_q, state_d;
    owner_t                 owner_q, owner_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   host_win, acc_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_HOST;
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_HOST: if (accel_busy)  state_d = ARB_ACC;
            ARB_ACC:  if (!accel_busy) state_d = ARB_HOST;
            default:  state_d = ARB_HOST;
        endcase
    end

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        host_win = 1'b0;
        acc_win  = 1'b0;
        if (rst_n) begin
            if (host_req && acc_req) begin
                if (state_q == ARB_HOST || wait_cnt_q >= WAIT_LIMIT) host_win = 1'b1;
                else                                                 acc_win  = 1'b1;
            end else begin
                host_win = host_req;
                acc_win  = acc_req;
            end
        end
    end

    always_comb begin
        mem_en    = host_win | acc_win;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (host_win) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_be    = host_be;
            mem_wdata = host_wdata;
        end else if (acc_win) begin
            mem_addr  = acc_addr;
            mem_we    = acc_we;
            mem_be    = acc_be;
            mem_wdata = acc_wdata;
        end
    end

    always_comb begin
        owner_d    = host_win ? OWN_HOST : (acc_win ? OWN_ACC : OWN_NONE);
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;
        if (host_win) begin
            wait_cnt_d = '0;
        end else if (host_req) begin
            if (wait_cnt_q < WAIT_LIMIT) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (stall_q != '1)           stall_d    = stall_q + STALL_CNT_W'(1);
        end
    end

    assign host_gnt       = host_win;
    assign acc_gnt        = acc_win;
    assign host_rvalid    = (owner_q == OWN_HOST);
    assign acc_rvalid     = (owner_q == OWN_ACC);
    assign host_rdata     = host_rvalid ? mem_rdata : '0;
    assign acc_rdata      = acc_rvalid  ? mem_rdata : '0;
    assign arb_state      = state_q;
    assign host_stall_cnt = stall_q;

    logic unused_be;
    assign unused_be = ^{BE_W{1'b0}};

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Directed test of accel_mem_arbiter with a behavioural RAM on port a.
// A negedge monitor scoreboards every grant against the response one cycle later.
module tb_accel_mem_arbiter;
    import cfg_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        accel_busy;
    logic        host_req, host_we, acc_req, acc_we;
    logic [9:0]  host_addr, acc_addr;
    logic [3:0]  host_be, acc_be;
    logic [31:0] host_wdata, acc_wdata;
    logic        host_gnt, host_rvalid, acc_gnt, acc_rvalid;
    logic [31:0] host_rdata, acc_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    arb_state_t  arb_state;
    logic [15:0] host_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_host;
        logic        is_read;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t   sb[$];
    sb_entry_t   mon_e;
    logic [31:0] ram    [0:1023];
    logic [31:0] shadow [0:1023];

    accel_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .accel_busy(accel_busy),
        .host_req(host_req), .host_addr(host_addr), .host_we(host_we), .host_be(host_be),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .acc_req(acc_req), .acc_addr(acc_addr), .acc_we(acc_we), .acc_be(acc_be),
        .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
        .acc_rdata(acc_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .arb_state(arb_state), .host_stall_cnt(host_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'h5A3C0000 ^ (i * 32'h00010003);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we && mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Response check first (previous cycle's grant), then record this cycle's grant.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("sb_host_rvalid", {31'd0, host_rvalid}, {31'd0, mon_e.is_host});
                check("sb_acc_rvalid", {31'd0, acc_rvalid}, {31'd0, !mon_e.is_host});
                if (mon_e.is_read)
                    check(mon_e.is_host ? "sb_host_rdata" : "sb_acc_rdata",
                          mon_e.is_host ? host_rdata : acc_rdata, mon_e.data);
            end else begin
                check("sb_no_rvalid", {30'd0, host_rvalid, acc_rvalid}, 32'd0);
            end
            if (!host_rvalid) check("host_rdata_zero", host_rdata, 32'd0);
            if (!acc_rvalid)  check("acc_rdata_zero", acc_rdata, 32'd0);
            check("gnt_onehot", {31'd0, host_gnt & acc_gnt}, 32'd0);
            check("gnt_needs_req", {30'd0, host_gnt & ~host_req, acc_gnt & ~acc_req}, 32'd0);
            check("mem_en", {31'd0, mem_en}, {31'd0, host_gnt | acc_gnt});
            if (host_gnt || acc_gnt) begin
                mon_e.is_host = host_gnt;
                mon_e.is_read = host_gnt ? !host_we : !acc_we;
                mon_e.data    = shadow[host_gnt ? host_addr : acc_addr];
                sb.push_back(mon_e);
                check("mem_addr", {22'd0, mem_addr}, {22'd0, host_gnt ? host_addr : acc_addr});
                check("mem_we_be", {27'd0, mem_we, mem_be},
                      host_gnt ? {27'd0, host_we, host_be} : {27'd0, acc_we, acc_be});
                if (mem_we) check("mem_wdata", mem_wdata, host_gnt ? host_wdata : acc_wdata);
                for (int b = 0; b < 4; b++) begin
                    if (host_gnt && host_we && host_be[b])
                        shadow[host_addr][8*b +: 8] <= host_wdata[8*b +: 8];
                    if (acc_gnt && acc_we && acc_be[b])
                        shadow[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end else begin
                check("mem_idle", {27'd0, mem_we, mem_be}, 32'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        rst_n = 1'b0; accel_busy = 1'b0;
        host_req = 1'b1; host_addr = 10'h0; host_we = 1'b0; host_be = 4'hF; host_wdata = '0;
        acc_req  = 1'b1; acc_addr  = 10'h0; acc_we  = 1'b0; acc_be  = 4'hF; acc_wdata  = '0;

        // Reset state, grants suppressed while held
        #2;
        check("rst_gnt", {30'd0, host_gnt, acc_gnt}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_state", {31'd0, arb_state}, {31'd0, ARB_HOST});
        check("rst_stall", {16'd0, host_stall_cnt}, 32'd0);
        check("rst_rvalid", {30'd0, host_rvalid, acc_rvalid}, 32'd0);
        cyc(); cyc();
        host_req = 1'b0; acc_req = 1'b0; rst_n = 1'b1;

        // Idle host read of 0x010
        cyc();
        host_req = 1'b1; host_addr = 10'h010;
        #1 check("r18_host_gnt", {30'd0, host_gnt, acc_gnt}, 32'd2);
        cyc();
        host_req = 1'b0;
        #1 check("r18_host_rvalid", {31'd0, host_rvalid}, 32'd1);
        check("r18_host_rdata", host_rdata, init_val(16));

        // Simultaneous reads in host mode
        cyc();
        host_req = 1'b1; host_addr = 10'h004; acc_req = 1'b1; acc_addr = 10'h008;
        #1 check("r20_first_gnt", {30'd0, host_gnt, acc_gnt}, 32'd2);
        cyc();
        host_req = 1'b0;
        #1 check("r20_second_gnt", {30'd0, host_gnt, acc_gnt}, 32'd1);
        check("r20_host_rsp", {30'd0, host_rvalid, acc_rvalid}, 32'd2);
        check("r20_host_rdata", host_rdata, init_val(4));
        cyc();
        acc_req = 1'b0;
        #1 check("r20_acc_rsp", {30'd0, host_rvalid, acc_rvalid}, 32'd1);
        check("r20_acc_rdata", acc_rdata, init_val(8));

        // Partial-byte accelerator write, then host read-back
        cyc();
        acc_req = 1'b1; acc_we = 1'b1; acc_addr = 10'h020; acc_be = 4'b0011;
        acc_wdata = 32'hDEADBEEF;
        #1 check("r21_acc_wr_gnt", {31'd0, acc_gnt}, 32'd1);
        cyc();
        acc_req = 1'b0; acc_we = 1'b0; acc_be = 4'hF;
        host_req = 1'b1; host_addr = 10'h020;
        #1 check("r21_host_gnt", {31'd0, host_gnt}, 32'd1);
        cyc();
        host_req = 1'b0;
        #1 check("r21_host_rdata", host_rdata, {init_val(32'h20) >> 16, 16'hBEEF});

        // Accelerator mode starvation limit
        cyc();
        accel_busy = 1'b1;
        #1 check("r19_state_lag", {31'd0, arb_state}, {31'd0, ARB_HOST});
        cyc();
        check("r19_state_acc", {31'd0, arb_state}, {31'd0, ARB_ACC});
        host_req = 1'b1; host_addr = 10'h030; acc_req = 1'b1; acc_addr = 10'h040;
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("r19_acc_win_%0d", i), {30'd0, host_gnt, acc_gnt}, 32'd1);
            cyc();
            acc_addr = 10'h041 + 10'(i);
        end
        #1 check("r19_host_win", {30'd0, host_gnt, acc_gnt}, 32'd2);
        check("r19_wait_sat", {28'd0, dut.wait_cnt_q}, 32'd8);
        cyc();
        host_req = 1'b0; acc_req = 1'b0;
        #1 check("r19_wait_clear", {28'd0, dut.wait_cnt_q}, 32'd0);
        check("r19_stall_cnt", {16'd0, host_stall_cnt}, 32'd8);

        // accel_busy drops in the cycle of an acc read grant
        cyc();
        acc_req = 1'b1; acc_addr = 10'h050; accel_busy = 1'b0;
        #1 check("r22_acc_gnt", {31'd0, acc_gnt}, 32'd1);
        check("r22_state_before", {31'd0, arb_state}, {31'd0, ARB_ACC});
        cyc();
        acc_req = 1'b0;
        #1 check("r22_acc_rvalid", {31'd0, acc_rvalid}, 32'd1);
        check("r22_acc_rdata", acc_rdata, init_val(32'h50));
        check("r22_state_after", {31'd0, arb_state}, {31'd0, ARB_HOST});

        // Reset right after a host grant drops the pending response
        cyc();
        accel_busy = 1'b1;
        cyc();
        host_req = 1'b1; host_addr = 10'h060;
        #1 check("r23_state_acc", {31'd0, arb_state}, {31'd0, ARB_ACC});
        check("r23_host_gnt", {31'd0, host_gnt}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1 check("r23_gnt_in_rst", {30'd0, host_gnt, acc_gnt}, 32'd0);
        check("r23_state_rst", {31'd0, arb_state}, {31'd0, ARB_HOST});
        check("r23_stall_rst", {16'd0, host_stall_cnt}, 32'd0);
        check("r23_wait_rst", {28'd0, dut.wait_cnt_q}, 32'd0);
        cyc();
        check("r23_no_rvalid", {30'd0, host_rvalid, acc_rvalid}, 32'd0);
        host_req = 1'b0; accel_busy = 1'b0; rst_n = 1'b1;
        cyc(); cyc();
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
